// File: rtl/int_dot_pkg.sv
// Shared types and width helpers for the integer dot-product accumulator.
//   state_e     : accumulator FSM state encoding
//   prod_width  : width of one signed element product
//   sum_width   : width of the adder-tree sum over n products
//   is_pow2     : true when n is a positive power of two
package int_dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int prod_width(input int dw);
    return 2 * dw;
  endfunction

  function automatic int sum_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/int_vector_adder_tree.sv
// Balanced binary adder tree reducing Size integers to one sum (combinational).
//   in_i   : Size operands of DataWidth bits each
//   sum_o  : exact sum, DataWidth + $clog2(Size) bits
//   Signed : 1 sign-extends operands, 0 zero-extends
module int_vector_adder_tree #(
  parameter int DataWidth = 16,
  parameter int Size      = 8,
  parameter bit Signed    = 1'b1
) (
  input  logic [Size-1:0][DataWidth-1:0]        in_i,
  output logic [DataWidth+$clog2(Size)-1:0]     sum_o
);

  localparam int Levels = $clog2(Size);
  localparam int OutW   = DataWidth + Levels;

  if (Size < 2 || (Size & (Size - 1)) != 0) begin : g_bad_size
    $error("int_vector_adder_tree: Size must be a power of two >= 2");
  end

  // Every node is carried at the final width so no level can overflow.
  logic [OutW-1:0] lvl [Levels+1][Size];

  always_comb begin
    for (int l = 0; l <= Levels; l++) begin
      for (int j = 0; j < Size; j++) begin
        lvl[l][j] = '0;
      end
    end
    for (int j = 0; j < Size; j++) begin
      lvl[0][j] = Signed ? OutW'($signed(in_i[j])) : OutW'(in_i[j]);
    end
    for (int l = 1; l <= Levels; l++) begin
      for (int j = 0; j < (Size >> l); j++) begin
        lvl[l][j] = lvl[l-1][2*j] + lvl[l-1][2*j+1];
      end
    end
  end

  assign sum_o = lvl[Levels][0];

endmodule

// File: rtl/int_vector_multiplier.sv
// Element-wise integer vector multiplier (combinational).
//   a_i, b_i : Size operands of DataWidth bits each
//   prod_o   : Size full-width products of 2*DataWidth bits each
//   Signed   : 1 treats operands as two's complement, 0 as unsigned
module int_vector_multiplier #(
  parameter int DataWidth = 8,
  parameter int Size      = 8,
  parameter bit Signed    = 1'b1
) (
  input  logic [Size-1:0][DataWidth-1:0]   a_i,
  input  logic [Size-1:0][DataWidth-1:0]   b_i,
  output logic [Size-1:0][2*DataWidth-1:0] prod_o
);

  for (genvar i = 0; i < Size; i++) begin : g_lane
    logic [2*DataWidth-1:0] ea;
    logic [2*DataWidth-1:0] eb;

    // Extending both operands to full product width first makes the
    // truncated product exact for either signedness.
    assign ea = Signed ? {{DataWidth{a_i[i][DataWidth-1]}}, a_i[i]}
                       : {{DataWidth{1'b0}}, a_i[i]};
    assign eb = Signed ? {{DataWidth{b_i[i][DataWidth-1]}}, b_i[i]}
                       : {{DataWidth{1'b0}}, b_i[i]};
    assign prod_o[i] = ea * eb;
  end

endmodule

// File: rtl/int_dot_accumulator.sv
// Multi-beat signed integer dot-product accumulator.
//   op0_vec_i/op1_vec_i : Size signed elements per beat
//   in_valid_i/in_ready_o/in_last_i : input beat handshake, last marks end
//   acc_o      : signed dot product (wraps at AccWidth)
//   beats_o    : beats folded into acc_o
//   overflow_o : a signed wrap happened while building this result
//   out_valid_o/out_ready_i : result handshake
//
// state | meaning
// IDLE  | no dot product in progress, ready for a first beat
// ACCUM | partial sum held, more beats expected
// HOLD  | result presented, waiting for out_ready_i
module int_dot_accumulator
  import int_dot_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int Size      = 8,
  parameter int AccWidth  = 32,
  parameter int MaxBeats  = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [Size-1:0][DataWidth-1:0]      op0_vec_i,
  input  logic [Size-1:0][DataWidth-1:0]      op1_vec_i,
  input  logic                                in_valid_i,
  input  logic                                in_last_i,
  output logic                                in_ready_o,
  output logic [AccWidth-1:0]                 acc_o,
  output logic [$clog2(MaxBeats+1)-1:0]       beats_o,
  output logic                                overflow_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i
);

  localparam int ProdW = prod_width(DataWidth);
  localparam int SumW  = sum_width(DataWidth, Size);
  localparam int CntW  = $clog2(MaxBeats + 1);

  if (Size < 2 || !is_pow2(Size)) begin : g_bad_size
    $error("int_dot_accumulator: Size must be a power of two >= 2");
  end
  if (AccWidth < SumW) begin : g_bad_acc
    $error("int_dot_accumulator: AccWidth too small for one beat sum");
  end

  logic [Size-1:0][ProdW-1:0] prods;
  logic [SumW-1:0]            beat_sum;
  logic [AccWidth-1:0]        beat_ext;
  logic [AccWidth-1:0]        acc_sum;
  logic                       add_ovf;
  logic                       accept;
  logic                       new_dot;
  logic                       last_beat;
  logic [CntW-1:0]            cnt_next;

  state_e              state_q;
  logic [AccWidth-1:0] acc_q;
  logic [CntW-1:0]     count_q;
  logic                ovf_q;

  int_vector_multiplier #(
    .DataWidth(DataWidth),
    .Size     (Size),
    .Signed   (1'b1)
  ) u_mul (
    .a_i   (op0_vec_i),
    .b_i   (op1_vec_i),
    .prod_o(prods)
  );

  int_vector_adder_tree #(
    .DataWidth(ProdW),
    .Size     (Size),
    .Signed   (1'b1)
  ) u_tree (
    .in_i (prods),
    .sum_o(beat_sum)
  );

  assign beat_ext = AccWidth'($signed(beat_sum));
  assign acc_sum  = acc_q + beat_ext;
  // Overflow only when both addends share a sign the result does not.
  assign add_ovf  = (acc_q[AccWidth-1] == beat_ext[AccWidth-1]) &&
                    (acc_sum[AccWidth-1] != acc_q[AccWidth-1]);

  // Accepting in HOLD is only safe when the held result leaves this cycle.
  assign in_ready_o = (state_q == HOLD) ? out_ready_i : 1'b1;
  assign accept     = in_valid_i && in_ready_o;
  assign new_dot    = (state_q != ACCUM);
  assign cnt_next   = new_dot ? CntW'(1) : count_q + CntW'(1);
  assign last_beat  = in_last_i || (cnt_next == CntW'(MaxBeats));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      acc_q   <= new_dot ? beat_ext : acc_sum;
      count_q <= cnt_next;
      ovf_q   <= new_dot ? 1'b0 : (ovf_q | add_ovf);
      state_q <= last_beat ? HOLD : ACCUM;
    end else if (state_q == HOLD && out_ready_i) begin
      state_q <= IDLE;
    end
  end

  assign out_valid_o = (state_q == HOLD);
  assign acc_o       = acc_q;
  assign beats_o     = count_q;
  assign overflow_o  = ovf_q;

endmodule

// File: doc/int_dot_accumulator.md
INT_DOT_ACCUMULATOR -- requirements
Module: int_dot_accumulator

Interface
REQ-001 Parameter DataWidth, default 8: element width of each operand.
REQ-002 Parameter Size, default 8: elements per beat; power of 2, >= 2.
REQ-003 Parameter AccWidth, default 32: accumulator width; legal only if >= 2*DataWidth + $clog2(Size).
REQ-004 Parameter MaxBeats, default 256: maximum beats per dot product.
REQ-005 Port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 Port op0_vec_i  input  [Size-1:0][DataWidth-1:0]  signed operand vector A.
REQ-008 Port op1_vec_i  input  [Size-1:0][DataWidth-1:0]  signed operand vector B.
REQ-009 Port in_valid_i  input  1  input beat valid.
REQ-010 Port in_last_i  input  1  beat is the final beat of the current dot product.
REQ-011 Port in_ready_o  output  1  beat accepted when in_valid_i && in_ready_o.
REQ-012 Port acc_o  output  AccWidth  signed dot-product result.
REQ-013 Port beats_o  output  $clog2(MaxBeats+1)  beats accumulated into acc_o.
REQ-014 Port overflow_o  output  1  signed overflow occurred during this result.
REQ-015 Port out_valid_o  output  1  result valid.
REQ-016 Port out_ready_i  input  1  result consumed when out_valid_o && out_ready_i.

Function
REQ-017 Each accepted beat: element-wise signed products (2*DataWidth bits), reduced by signed adder tree to 2*DataWidth+$clog2(Size) bits, sign-extended to AccWidth.
REQ-018 FSM states IDLE, ACCUM, HOLD; out_valid_o = (state == HOLD).
REQ-019 IDLE/ACCUM: in_ready_o = 1; HOLD: in_ready_o = out_ready_i.
REQ-020 Beat accepted in IDLE or HOLD (new dot product): acc_q <= beat sum, count_q <= 1, ovf_q <= 0.
REQ-021 Beat accepted in ACCUM: acc_q <= acc_q + beat sum (two's-complement wrap), count_q++, ovf_q |= signed overflow of this add.
REQ-022 Accepted beat with in_last_i = 1, or count reaching MaxBeats (implicit last): next state HOLD; else ACCUM.
REQ-023 Latency: result valid the cycle after the last beat is accepted; one beat per cycle throughput.
REQ-024 HOLD: acc_o, beats_o, overflow_o stable until handshake; no beat accepted while out_ready_i = 0.
REQ-025 HOLD with output handshake and no input beat: next state IDLE.
REQ-026 HOLD with output handshake and input beat same cycle: both complete; beat starts new dot product per REQ-020.
REQ-027 IDLE/ACCUM with in_valid_i = 0: all state held.
REQ-028 acc_o, beats_o, overflow_o driven directly from registers; no combinational path input-to-output except out_ready_i -> in_ready_o.

Reset
REQ-029 rst_i asserted (any cycle, incl. mid-ACCUM or HOLD): state IDLE, acc_q 0, count_q 0, ovf_q 0, out_valid_o 0, in_ready_o 1; partial result discarded.
REQ-030 First beat accepted after reset deassertion starts a new dot product.

Structure
REQ-031 Package int_dot_pkg holds state enum (IDLE, ACCUM, HOLD) and width helper functions (product, tree-sum widths).
REQ-032 Combinational datapath reuses int_vector_multiplier (Signed=1) and int_vector_adder_tree (Signed=1, DataWidth=2*DataWidth); no new sub-module.
REQ-033 Elaboration error if AccWidth rule (REQ-003) or power-of-2 Size is violated.

Verification (DataWidth=8, Size=4, AccWidth=24, MaxBeats=4 unless stated)
REQ-034 Single beat A={1,2,3,4}, B={5,6,7,8}, last=1 -> next cycle out_valid_o=1, acc_o=70, beats_o=1, overflow_o=0.
REQ-035 Three beats A,B all -128, last on 3rd -> acc_o=196608, beats_o=3, overflow_o=0.
REQ-036 Result pending, out_ready_i=0 for 5 cycles -> in_ready_o=0, outputs stable; then out_ready_i=1 with new beat A={1,1,1,1}, B={2,2,2,2}, last -> both handshake, next result acc_o=8.
REQ-037 Four beats A={1,0,0,0}, B={1,0,0,0}, in_last_i never set -> result after 4th beat, acc_o=4, beats_o=4.
REQ-038 AccWidth=18, two beats A,B all -128, last on 2nd -> acc_o=-131072, overflow_o=1.
REQ-039 rst_i pulsed after 2 of 3 beats -> no result; next single beat {1,2,3,4}·{5,6,7,8} last -> acc_o=70, beats_o=1.
